// File: rtl/pipe_scheduler.sv
// pipe_scheduler
// Keeps a pool of N_PIPES obstacle slots for a side-scrolling game. On every
// frame tick while the round is running it scrolls the pipes left, retires
// pipes that leave the screen, spawns new pipes at a fixed scrolled distance,
// and counts the pipes that the bird has passed. The scroll speed rises with
// the score.
//
// Ports
//   clk, rst_n   : system clock (rising edge), asynchronous active-low reset
//   state        : game state 00 START, 01 GAME, 10 GAMEOVER, 11 as START
//   game_rst     : one-cycle synchronous round clear (wins over frame_tick)
//   frame_tick   : one-cycle pulse per video frame
//   bird_x       : bird left edge x
//   pipe_valid   : slot occupied flags
//   pipe_x       : packed left edge x, slot i at [11i+10:11i]
//   pipe_gap_y   : packed gap centre y, slot i at [10i+9:10i]
//   score        : passed-pipe count, saturating at 255
//   speed        : current scroll speed (pixels/frame)
//   spawn_drop   : sticky, a spawn was lost because the pool was full
//   dbg_fsm      : current mode, 0 CLEAR, 1 RUN, 2 FREEZE
module pipe_scheduler #(
  parameter int N_PIPES    = 4,
  parameter int SCREEN_W   = 800,
  parameter int PIPE_W     = 60,
  parameter int SPAWN_DIST = 256,
  parameter int SPEED_BASE = 2,
  parameter int SPEED_MAX  = 6,
  parameter int GAP_MIN    = 100
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             state,
  input  logic                   game_rst,
  input  logic                   frame_tick,
  input  logic [10:0]            bird_x,
  output logic [N_PIPES-1:0]     pipe_valid,
  output logic [11*N_PIPES-1:0]  pipe_x,
  output logic [10*N_PIPES-1:0]  pipe_gap_y,
  output logic [7:0]             score,
  output logic [2:0]             speed,
  output logic                   spawn_drop,
  output logic [1:0]             dbg_fsm
);

  localparam int ACC_W = $clog2(SPAWN_DIST + SPEED_MAX + 1) + 1;

  typedef enum logic [1:0] {
    M_CLEAR  = 2'd0,
    M_RUN    = 2'd1,
    M_FREEZE = 2'd2
  } mode_e;

  mode_e              fsm_q, mode_d;
  logic [1:0]         sync_q;
  logic [9:0]         lfsr_q, lfsr_d;
  logic [N_PIPES-1:0] valid_q, valid_d;
  logic [N_PIPES-1:0] passed_q, passed_d;
  logic [10:0]        x_q [N_PIPES];
  logic [10:0]        x_d [N_PIPES];
  logic [9:0]         gap_q [N_PIPES];
  logic [9:0]         gap_d [N_PIPES];
  logic [7:0]         score_q, score_d;
  logic [2:0]         speed_q, speed_d;
  logic               drop_q, drop_d;
  logic [ACC_W-1:0]   acc_q, acc_d;

  logic [N_PIPES-1:0] free_oh;
  logic [ACC_W-1:0]   acc_sum;
  logic               spawn;
  logic [7:0]         pass_cnt;
  logic [8:0]         score_sum;
  logic [5:0]         speed_sum;

  always_comb begin
    // Mode is decided from this cycle's inputs so a state change or
    // game_rst acts on the very next edge. Until the reset synchroniser
    // has filled, the block behaves as CLEAR.
    mode_d = M_CLEAR;
    if (sync_q[1] && !game_rst) begin
      case (state)
        2'b01:   mode_d = M_RUN;
        2'b10:   mode_d = M_FREEZE;
        default: mode_d = M_CLEAR;
      endcase
    end

    // x^10 + x^7 + 1 Fibonacci LFSR, free running
    lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};

    valid_d  = valid_q;
    passed_d = passed_q;
    x_d      = x_q;
    gap_d    = gap_q;
    score_d  = score_q;
    drop_d   = drop_q;
    acc_d    = acc_q;

    // Lowest-index free slot, one-hot, taken before this tick's retirements
    free_oh   = ~valid_q & (valid_q + N_PIPES'(1));
    acc_sum   = acc_q + ACC_W'(speed_q);
    spawn     = (acc_sum >= ACC_W'(SPAWN_DIST));
    pass_cnt  = 8'd0;

    speed_sum = 6'(SPEED_BASE) + {1'b0, score_q[7:3]};
    speed_d   = (speed_sum > 6'(SPEED_MAX)) ? 3'(SPEED_MAX) : speed_sum[2:0];

    case (mode_d)
      M_CLEAR: begin
        valid_d  = '0;
        passed_d = '0;
        score_d  = 8'd0;
        drop_d   = 1'b0;
        acc_d    = '0;
        speed_d  = 3'(SPEED_BASE);
        for (int i = 0; i < N_PIPES; i++) begin
          x_d[i]   = 11'd0;
          gap_d[i] = 10'd0;
        end
      end
      M_RUN: begin
        if (frame_tick) begin
          acc_d = spawn ? (acc_sum - ACC_W'(SPAWN_DIST)) : acc_sum;
          for (int i = 0; i < N_PIPES; i++) begin
            if (valid_q[i]) begin
              if (x_q[i] >= {8'd0, speed_q}) begin
                x_d[i] = x_q[i] - {8'd0, speed_q};
                // Pass test on the moved position, compared at 12 bits
                if (!passed_q[i] &&
                    (({1'b0, x_d[i]} + 12'(PIPE_W)) < {1'b0, bird_x})) begin
                  passed_d[i] = 1'b1;
                  pass_cnt    = pass_cnt + 8'd1;
                end
              end else begin
                valid_d[i]  = 1'b0;
                passed_d[i] = 1'b0;
              end
            end else if (spawn && free_oh[i]) begin
              valid_d[i]  = 1'b1;
              passed_d[i] = 1'b0;
              x_d[i]      = 11'(SCREEN_W);
              gap_d[i]    = 10'(GAP_MIN) + {2'b00, lfsr_q[7:0]};
            end
          end
          if (spawn && (free_oh == '0)) begin
            drop_d = 1'b1;
          end
          score_sum = {1'b0, score_q} + {1'b0, pass_cnt};
          score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
        end
      end
      default: begin
        // FREEZE: everything holds
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= M_CLEAR;
      sync_q   <= 2'b00;
      lfsr_q   <= 10'h2A5;
      valid_q  <= '0;
      passed_q <= '0;
      score_q  <= 8'd0;
      speed_q  <= 3'(SPEED_BASE);
      drop_q   <= 1'b0;
      acc_q    <= '0;
      for (int i = 0; i < N_PIPES; i++) begin
        x_q[i]   <= 11'd0;
        gap_q[i] <= 10'd0;
      end
    end else begin
      fsm_q    <= mode_d;
      sync_q   <= {sync_q[0], 1'b1};
      lfsr_q   <= lfsr_d;
      valid_q  <= valid_d;
      passed_q <= passed_d;
      score_q  <= score_d;
      speed_q  <= speed_d;
      drop_q   <= drop_d;
      acc_q    <= acc_d;
      x_q      <= x_d;
      gap_q    <= gap_d;
    end
  end

  for (genvar g = 0; g < N_PIPES; g++) begin : g_pack
    assign pipe_x[11*g +: 11]     = x_q[g];
    assign pipe_gap_y[10*g +: 10] = gap_q[g];
  end

  assign pipe_valid = valid_q;
  assign score      = score_q;
  assign speed      = speed_q;
  assign spawn_drop = drop_q;
  assign dbg_fsm    = fsm_q;

endmodule
